sm83_int_ctrl: RTL and testbench
================================

Name: sm83_int_ctrl

Overview:
Parametrised interrupt controller for the sm83 core. Owns the IF/IE registers and IME, arbitrates pending sources by fixed priority, and issues a vector to the control FSM through a valid/ack handshake. It also tracks HALT and wake-up, and detects the HALT-bug condition. It sits between the peripheral IRQ lines, the IO bus decoder (IF at 0xFF0F, IE at 0xFFFF) and the control unit's instruction-boundary logic.

Parameters:
NUM_IRQ, 5, number of interrupt sources; legal range 1..8; bit 0 has the highest priority.
VEC_BASE, 16'h0040, vector address of source 0.
VEC_STRIDE, 16'h0008, address step between consecutive source vectors.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
irq_req  in  NUM_IRQ  single-cycle event pulses from peripherals
if_wr  in  1  bus write strobe for IF
ie_wr  in  1  bus write strobe for IE
wdata  in  8  bus write data
if_rdata  out  8  IF readback
ie_rdata  out  8  IE readback
ctl_di  in  1  DI executed
ctl_ei  in  1  EI executed
ctl_reti  in  1  RETI executed
halt_req  in  1  HALT executed
instr_boundary  in  1  control unit is about to fetch the next opcode
irq_valid  out  1  dispatch request to the control unit
irq_vec  out  16  vector address; stable while irq_valid is high
irq_ack  in  1  control unit accepts the vector
halted  out  1  core is halted
wake  out  1  one-cycle pulse when a halt is exited
halt_bug  out  1  one-cycle pulse: HALT executed with IME=0 and an interrupt already pending
ime  out  1  interrupt master enable

Behaviour:
- Reset: IF=0, IE=0, ime=0, ime_pend=0, state IDLE. All outputs 0, except if_rdata, which reads {(8-NUM_IRQ){1}, zeros}.
- Next-IF per bit: if_wr loads the bit from wdata; an ack clears the serviced bit; irq_req sets the bit.
  - Priority: irq_req > ack clear > if_wr > hold.
  - A new event arriving on the same cycle as an ack of the same bit is retained.
- IE: full 8-bit register. Only IE[NUM_IRQ-1:0] participates in arbitration.
- Readback: if_rdata = unused upper bits read as 1, plus IF; combinational from registers.
- pending = |(IF & IE[NUM_IRQ-1:0]), evaluated from registered state.
- IME rules:
  - ctl_di: ime=0 and ime_pend=0 on the next edge.
  - ctl_ei: ime_pend=1. ime becomes 1 on the edge of the first instr_boundary after the EI cycle, so exactly one following instruction runs with ime=0.
  - ctl_reti: ime=1 immediately; no delay.
  - DI together with EI on the same cycle: DI wins.
  - Dispatch ack forces ime=0 and ime_pend=0.
- FSM states: IDLE, DISPATCH, HALTED.
  - IDLE -> DISPATCH: instr_boundary & ime & pending. The encoder index is latched, and irq_vec = VEC_BASE + idx*VEC_STRIDE (16-bit, no wrap check). irq_valid=1 from the next cycle.
  - DISPATCH: irq_valid and irq_vec hold until irq_ack. Later IF/IE changes do not alter the latched vector.
  - DISPATCH -> IDLE: on irq_ack, clear IF[idx] and ime. irq_valid drops the cycle after ack.
  - IDLE -> HALTED: halt_req when not (ime=0 & pending). halted=1 on the next cycle.
  - halt_req with ime=0 & pending: stay in IDLE and pulse halt_bug for 1 cycle.
  - HALTED -> IDLE: pending becomes 1 (independent of ime). wake pulses for 1 cycle and halted drops on the same edge. If ime=1, the following instr_boundary dispatches normally.
  - In HALTED, instr_boundary and the ctl_* inputs are ignored except IME updates; irq_ack is ignored.
  - irq_ack outside DISPATCH: no effect.
- Latency: irq_req pulse -> IF bit visible next cycle -> dispatch decision at the earliest instr_boundary one cycle later.
- Asynchronous reset mid-dispatch aborts the dispatch and clears everything to reset values. The control unit must treat irq_valid dropping as an abort.

Decomposition:
- Package sm83_pkg gains:
  - int_state_t {INT_IDLE, INT_DISPATCH, INT_HALTED}.
  - int_src_t {INT_VBLANK, INT_STAT, INT_TIMER, INT_SERIAL, INT_JOYPAD}.
  - Localparams INT_IF_ADDR=16'hFF0F, INT_IE_ADDR=16'hFFFF.
- One sub-module: sm83_int_prio_enc. Parametrised by NUM_IRQ; lowest-set-bit index plus a valid bit; purely combinational. The top module instantiates it once on IF & IE.

Test Plan:
- Reset, then read IF/IE -> if_rdata=8'hE0, ie_rdata=0, ime=0, irq_valid=0.
- IE=8'h1F, RETI, irq_req=5'b00100, instr_boundary -> irq_valid, irq_vec=16'h0050. Ack -> IF=8'hE0, ime=0.
- IE=8'h1F, irq_req=5'b10010 with ime=1 -> vector 16'h0048 first. After ack and RETI -> 16'h0060.
- EI, then pending interrupt at the next instr_boundary -> no dispatch. At the second instr_boundary -> dispatch.
- ime=0, IE=8'h04, HALT, then irq_req[2] -> halted=1, then wake pulse, halted=0, no irq_valid. Repeat with ime=1 -> dispatch to 16'h0050 after wake.
- ime=0, IF&IE already set, HALT -> halt_bug pulse, halted stays 0.
- Same cycle: ack of bit 0 with irq_req[0]=1 -> IF[0] remains 1.
- Same cycle: if_wr 8'h00 with irq_req[3] -> IF=8'hE8.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared types and constants for the sm83 interrupt controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm83_pkg;

    typedef enum logic [1:0] {
        INT_IDLE     = 2'd0,
        INT_DISPATCH = 2'd1,
        INT_HALTED   = 2'd2
    } int_state_t;

    typedef enum logic [2:0] {
        INT_VBLANK = 3'd0,
        INT_STAT   = 3'd1,
        INT_TIMER  = 3'd2,
        INT_SERIAL = 3'd3,
        INT_JOYPAD = 3'd4
    } int_src_t;

    localparam logic [15:0] INT_IF_ADDR = 16'hFF0F;
    localparam logic [15:0] INT_IE_ADDR = 16'hFFFF;

    // Vector for source idx; 16-bit arithmetic, wraps silently.
    function automatic logic [15:0] int_vec_addr(input logic [15:0] base,
                                                 input logic [15:0] stride,
                                                 input logic [2:0]  idx);
        logic [15:0] w_idx16;
        w_idx16 = {13'd0, idx};
        return base + (w_idx16 * stride);
    endfunction

endpackage

// File: rtl/sm83_int_ctrl_if.sv
// Bus, control-unit and dispatch signals of the interrupt controller.
// Latency: n/a (wiring only).
// Backpressure: dispatch is valid/ack; irq_vec held until ack.
interface sm83_int_ctrl_if #(
    parameter int NUM_IRQ = 5
);
    logic [NUM_IRQ-1:0] irq_req;
    logic               if_wr;
    logic               ie_wr;
    logic [7:0]         wdata;
    logic [7:0]         if_rdata;
    logic [7:0]         ie_rdata;
    logic               ctl_di;
    logic               ctl_ei;
    logic               ctl_reti;
    logic               halt_req;
    logic               instr_boundary;
    logic               irq_valid;
    logic [15:0]        irq_vec;
    logic               irq_ack;
    logic               halted;
    logic               wake;
    logic               halt_bug;
    logic               ime;

    // Controller side.
    modport slave (
        input  irq_req, if_wr, ie_wr, wdata, ctl_di, ctl_ei, ctl_reti,
               halt_req, instr_boundary, irq_ack,
        output if_rdata, ie_rdata, irq_valid, irq_vec, halted, wake,
               halt_bug, ime
    );

    // Core / peripheral side.
    modport master (
        output irq_req, if_wr, ie_wr, wdata, ctl_di, ctl_ei, ctl_reti,
               halt_req, instr_boundary, irq_ack,
        input  if_rdata, ie_rdata, irq_valid, irq_vec, halted, wake,
               halt_bug, ime
    );
endinterface

// File: rtl/sm83_int_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit plus a valid flag.
// Latency: combinational.
// Backpressure: none.
module sm83_int_prio_enc #(
    parameter int NUM_IRQ = 5
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic [2:0]         o_idx,
    output logic               o_vld
);

    // Scan from the top down so the lowest set bit is the last to assign.
    always_comb begin
        o_idx = 3'd0;
        o_vld = |i_req;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = 3'(i);
        end
    end

endmodule

// File: rtl/sm83_int_ctrl.sv
// Interrupt controller: IF/IE/IME, fixed-priority dispatch, HALT/wake, HALT-bug detect.
// Latency: irq_req -> IF next cycle; dispatch decided on an instr_boundary, irq_valid the cycle after.
// Backpressure: irq_valid/irq_vec held until irq_ack; valid drops the cycle after ack.
module sm83_int_ctrl
    import sm83_pkg::*;
#(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sm83_int_ctrl_if.slave         bus
);

    localparam logic [1:0] ST_IDLE     = INT_IDLE;
    localparam logic [1:0] ST_DISPATCH = INT_DISPATCH;
    localparam logic [1:0] ST_HALTED   = INT_HALTED;

    logic [NUM_IRQ-1:0] r_if;
    logic [7:0]         r_ie;
    logic               r_ime;
    logic               r_ime_pend;
    logic [1:0]         r_state;
    logic [2:0]         r_idx;
    logic [15:0]        r_vec;
    logic               r_wake;
    logic               r_halt_bug;

    logic [NUM_IRQ-1:0] w_active;
    logic [2:0]         w_enc_idx;
    logic               w_pending;
    logic               w_ack_take;
    logic [7:0]         w_if_rd;

    assign w_active   = r_if & r_ie[NUM_IRQ-1:0];
    assign w_ack_take = (r_state == ST_DISPATCH) && bus.irq_ack;

    sm83_int_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .i_req (w_active),
        .o_idx (w_enc_idx),
        .o_vld (w_pending)
    );

    // IF per bit: a new event beats the ack clear, which beats a bus write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if <= '0;
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (bus.irq_req[i])
                    r_if[i] <= 1'b1;
                else if (w_ack_take && (r_idx == 3'(i)))
                    r_if[i] <= 1'b0;
                else if (bus.if_wr)
                    r_if[i] <= bus.wdata[i];
            end
        end
    end

    // IE is a plain 8-bit register; only the low NUM_IRQ bits gate sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_ie <= 8'h00;
        else if (bus.ie_wr) r_ie <= bus.wdata;
    end

    // IME: ack and DI clear everything; RETI enables at once; EI arms a
    // pending enable that lands on the next instruction boundary after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ime      <= 1'b0;
            r_ime_pend <= 1'b0;
        end else if (w_ack_take || bus.ctl_di) begin
            r_ime      <= 1'b0;
            r_ime_pend <= 1'b0;
        end else begin
            if (bus.ctl_reti) r_ime <= 1'b1;
            if (bus.ctl_ei) begin
                r_ime_pend <= 1'b1;
            end else if (r_ime_pend && bus.instr_boundary) begin
                r_ime      <= 1'b1;
                r_ime_pend <= 1'b0;
            end
        end
    end

    // Dispatch / halt state machine with one-cycle wake and halt-bug pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= 3'd0;
            r_vec      <= 16'h0000;
            r_wake     <= 1'b0;
            r_halt_bug <= 1'b0;
        end else begin
            r_wake     <= 1'b0;
            r_halt_bug <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.instr_boundary && r_ime && w_pending) begin
                        r_state <= ST_DISPATCH;
                        r_idx   <= w_enc_idx;
                        r_vec   <= int_vec_addr(VEC_BASE, VEC_STRIDE, w_enc_idx);
                    end else if (bus.halt_req) begin
                        if (!r_ime && w_pending) r_halt_bug <= 1'b1;
                        else                     r_state    <= ST_HALTED;
                    end
                end
                ST_DISPATCH: begin
                    if (bus.irq_ack) r_state <= ST_IDLE;
                end
                ST_HALTED: begin
                    if (w_pending) begin
                        r_state <= ST_IDLE;
                        r_wake  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // IF readback: bits with no source read as 1.
    always_comb begin
        w_if_rd = 8'hFF;
        w_if_rd[NUM_IRQ-1:0] = r_if;
    end

    assign bus.if_rdata  = w_if_rd;
    assign bus.ie_rdata  = r_ie;
    assign bus.irq_valid = (r_state == ST_DISPATCH);
    assign bus.irq_vec   = r_vec;
    assign bus.halted    = (r_state == ST_HALTED);
    assign bus.wake      = r_wake;
    assign bus.halt_bug  = r_halt_bug;
    assign bus.ime       = r_ime;

endmodule

// File: tb/tb_sm83_int_ctrl.sv
// Bench for sm83_int_ctrl: directed stimulus, queued expected events, negedge monitor.
// Latency: n/a.
// Backpressure: bench acks each dispatch after observing irq_valid.
module tb_sm83_int_ctrl;

    localparam int EV_VEC  = 0;
    localparam int EV_WAKE = 1;
    localparam int EV_HBUG = 2;

    typedef struct {
        int          kind;
        logic [15:0] vec;
    } ev_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    ev_t  exp_q[$];
    logic prev_valid;
    logic [15:0] hold_vec;

    sm83_int_ctrl_if #(.NUM_IRQ(5)) bus ();

    sm83_int_ctrl #(
        .NUM_IRQ    (5),
        .VEC_BASE   (16'h0040),
        .VEC_STRIDE (16'h0008)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [15:0] vec);
        ev_t e;
        e.kind = kind;
        e.vec  = vec;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [15:0] vec);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d vec %h, expected no event", kind, vec);
        end else begin
            e = exp_q.pop_front();
            hold_vec = e.vec;
            if (e.kind != kind || (kind == EV_VEC && e.vec !== vec)) begin
                n_fail++;
                $display("FAIL event: got kind %0d vec %h, expected kind %0d vec %h",
                         kind, vec, e.kind, e.vec);
            end
        end
    endtask

    // Monitor: compare every DUT-presented event against the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.irq_valid && !prev_valid)
                pop_check(EV_VEC, bus.irq_vec);
            else if (bus.irq_valid)
                check("vec_stable", bus.irq_vec, hold_vec);
            if (bus.wake)     pop_check(EV_WAKE, 16'h0);
            if (bus.halt_bug) pop_check(EV_HBUG, 16'h0);
            prev_valid = bus.irq_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.irq_req        = '0;
        bus.if_wr          = 1'b0;
        bus.ie_wr          = 1'b0;
        bus.wdata          = 8'h00;
        bus.ctl_di         = 1'b0;
        bus.ctl_ei         = 1'b0;
        bus.ctl_reti       = 1'b0;
        bus.halt_req       = 1'b0;
        bus.instr_boundary = 1'b0;
        bus.irq_ack        = 1'b0;
    endtask

    task automatic wr_ie(input logic [7:0] v);
        bus.ie_wr = 1'b1; bus.wdata = v; tick(); clr();
    endtask

    task automatic wr_if(input logic [7:0] v);
        bus.if_wr = 1'b1; bus.wdata = v; tick(); clr();
    endtask

    task automatic req(input logic [4:0] v);
        bus.irq_req = v; tick(); clr();
    endtask

    task automatic reti();
        bus.ctl_reti = 1'b1; tick(); clr();
    endtask

    task automatic boundary();
        bus.instr_boundary = 1'b1; tick(); clr();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.irq_valid && n < 20) begin tick(); n++; end
        check("wait_valid", {15'd0, bus.irq_valid}, 16'd1);
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1; tick(); clr();
    endtask

    task automatic wait_unhalt();
        int n = 0;
        while (bus.halted && n < 20) begin tick(); n++; end
        check("wake_halted_low", {15'd0, bus.halted}, 16'd0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        prev_valid = 1'b0;
        hold_vec   = 16'h0;
        rst_n      = 1'b0;
        clr();
        repeat (3) tick();
        check("rst_if",     {8'd0, bus.if_rdata}, 16'h00E0);
        check("rst_ie",     {8'd0, bus.ie_rdata}, 16'h0000);
        check("rst_ime",    {15'd0, bus.ime}, 16'd0);
        check("rst_valid",  {15'd0, bus.irq_valid}, 16'd0);
        check("rst_halted", {15'd0, bus.halted}, 16'd0);
        rst_n = 1'b1;
        tick();

        // Single source 2 dispatch.
        wr_ie(8'h1F);
        check("ie_write", {8'd0, bus.ie_rdata}, 16'h001F);
        reti();
        check("reti_ime", {15'd0, bus.ime}, 16'd1);
        req(5'b00100);
        check("if_set2", {8'd0, bus.if_rdata}, 16'h00E4);
        push_ev(EV_VEC, 16'h0050);
        boundary();
        wait_valid();
        ack();
        check("ack_if",    {8'd0, bus.if_rdata}, 16'h00E0);
        check("ack_ime",   {15'd0, bus.ime}, 16'd0);
        check("ack_valid", {15'd0, bus.irq_valid}, 16'd0);

        // Two pending: source 1 wins, then source 4.
        req(5'b10010);
        reti();
        push_ev(EV_VEC, 16'h0048);
        boundary();
        wait_valid();
        ack();
        check("prio_if_left", {8'd0, bus.if_rdata}, 16'h00F0);
        push_ev(EV_VEC, 16'h0060);
        reti();
        boundary();
        wait_valid();
        ack();
        check("prio_if_empty", {8'd0, bus.if_rdata}, 16'h00E0);

        // EI delay: first boundary after EI does not dispatch.
        req(5'b00001);
        bus.ctl_ei = 1'b1; tick(); clr();
        check("ei_ime_still0", {15'd0, bus.ime}, 16'd0);
        boundary();
        check("ei_no_dispatch", {15'd0, bus.irq_valid}, 16'd0);
        check("ei_ime_now1", {15'd0, bus.ime}, 16'd1);
        tick();
        push_ev(EV_VEC, 16'h0040);
        boundary();
        wait_valid();
        ack();

        // HALT with ime=0: wake but no dispatch.
        wr_ie(8'h04);
        bus.halt_req = 1'b1; tick(); clr();
        check("halt_entered", {15'd0, bus.halted}, 16'd1);
        tick(); tick();
        check("halt_held", {15'd0, bus.halted}, 16'd1);
        push_ev(EV_WAKE, 16'h0);
        req(5'b00100);
        wait_unhalt();
        boundary();
        boundary();
        tick();
        check("halt_ime0_no_valid", {15'd0, bus.irq_valid}, 16'd0);
        wr_if(8'h00);

        // HALT with ime=1: wake then dispatch to source 2.
        reti();
        bus.halt_req = 1'b1; tick(); clr();
        check("halt1_entered", {15'd0, bus.halted}, 16'd1);
        push_ev(EV_WAKE, 16'h0);
        push_ev(EV_VEC, 16'h0050);
        req(5'b00100);
        wait_unhalt();
        boundary();
        wait_valid();
        ack();

        // HALT bug: ime=0 with a pending source.
        req(5'b00100);
        push_ev(EV_HBUG, 16'h0);
        bus.halt_req = 1'b1; tick(); clr();
        check("hbug_not_halted", {15'd0, bus.halted}, 16'd0);
        tick();
        check("hbug_still_idle", {15'd0, bus.halted}, 16'd0);
        wr_if(8'h00);

        // Ack and a new event on the same bit in the same cycle.
        wr_ie(8'h1F);
        req(5'b00001);
        reti();
        push_ev(EV_VEC, 16'h0040);
        boundary();
        wait_valid();
        bus.irq_ack = 1'b1; bus.irq_req = 5'b00001; tick(); clr();
        check("ack_req_same_if", {8'd0, bus.if_rdata}, 16'h00E1);
        check("ack_req_same_ime", {15'd0, bus.ime}, 16'd0);
        wr_if(8'h00);
        check("if_clear", {8'd0, bus.if_rdata}, 16'h00E0);

        // Event beats a bus write on the same cycle.
        bus.if_wr = 1'b1; bus.wdata = 8'h00; bus.irq_req = 5'b01000; tick(); clr();
        check("req_over_wr", {8'd0, bus.if_rdata}, 16'h00E8);
        wr_if(8'hFF);
        check("if_wr_all", {8'd0, bus.if_rdata}, 16'h00FF);
        wr_if(8'h00);

        // DI wins over EI on the same cycle.
        reti();
        bus.ctl_di = 1'b1; bus.ctl_ei = 1'b1; tick(); clr();
        boundary();
        boundary();
        check("di_over_ei", {15'd0, bus.ime}, 16'd0);

        // Asynchronous reset in the middle of a dispatch.
        req(5'b00010);
        reti();
        push_ev(EV_VEC, 16'h0048);
        boundary();
        wait_valid();
        tick();
        rst_n = 1'b0;
        #2;
        check("arst_valid", {15'd0, bus.irq_valid}, 16'd0);
        check("arst_if",    {8'd0, bus.if_rdata}, 16'h00E0);
        check("arst_ime",   {15'd0, bus.ime}, 16'd0);
        check("arst_ie",    {8'd0, bus.ie_rdata}, 16'h0000);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
